regfile_mp: RTL and testbench

Parametrised multi-port register file with same-cycle write-to-read bypass and a per-register busy scoreboard. It succeeds the fixed 32×32, 2-read/1-write, negedge-write register file in the pipelined RISC-V core. All state updates on the rising edge. The bypass network replaces the half-cycle write trick, and the scoreboard gives the decode stage hazard detection for multi-cycle producers.

---
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and a per-register
// busy scoreboard used by decode to detect hazards on multi-cycle producers.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic [NWRITE-1:0]       wen,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*WIDTH-1:0] wdata,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  input  logic                    flush
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Later ports overwrite earlier ones in the loop, giving the highest index priority.
  // Busy priority is rst > issue > flush > write, so the steps run in reverse order.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j] && !is_zero(waddr[j*AW +: AW])) begin
        regs_d[waddr[j*AW +: AW]] = wdata[j*WIDTH +: WIDTH];
        busy_d[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (flush) begin
      busy_d = '0;
    end
    if (iss_en && !is_zero(iss_addr)) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_d[k] = '0;
      end
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic             hit;
    logic [WIDTH-1:0] byp;

    assign ra = raddr[i*AW +: AW];

    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] == ra) && !is_zero(ra)) begin
          hit = 1'b1;
          byp = wdata[j*WIDTH +: WIDTH];
        end
      end
    end

    // A bypass hit means the producer is writing back now, so the read is not stalled.
    assign rdata[i*WIDTH +: WIDTH] = is_zero(ra) ? '0 : (hit ? byp : regs_q[ra]);
    assign rbusy[i]                = busy_q[ra] & ~hit & ~is_zero(ra);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus pushes expected per-port read results into
// a queue tagged with the cycle; a monitor pops and compares them on the falling edge.
module tb_regfile_mp;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*W-1:0]  rdata;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*W-1:0]  wdata;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;

  regfile_mp #(.WIDTH(W), .DEPTH(32), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
    logic        busy;
    bit          chk_data;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation registered for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
        end else begin
          if (e.chk_data) begin
            checks++;
            if (rdata[e.port*W +: W] !== e.data) begin
              errors++;
              $display("FAIL %s rdata%0d got=%h exp=%h", e.name, e.port,
                       rdata[e.port*W +: W], e.data);
            end
          end
          checks++;
          if (rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s rbusy%0d got=%b exp=%b", e.name, e.port, rbusy[e.port], e.busy);
          end
        end
      end
    end
  end

  // Advance to the next cycle and return all inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b0; wen = '0; waddr = '0; wdata = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; raddr = '0;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    wen[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*W +: W] = d;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_en = 1'b1;
    iss_addr = a;
  endtask

  task automatic expect_rd(input int p, input logic [31:0] d, input logic b, input string n);
    exp_t e;
    e.cyc = cyc; e.port = p; e.data = d; e.busy = b; e.chk_data = 1'b1; e.name = n;
    q.push_back(e);
  endtask

  task automatic expect_busy(input int p, input logic b, input string n);
    exp_t e;
    e.cyc = cyc; e.port = p; e.data = '0; e.busy = b; e.chk_data = 1'b0; e.name = n;
    q.push_back(e);
  endtask

  initial begin
    int guard;
    rst = 1'b1; wen = '0; waddr = '0; wdata = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; raddr = '0;
    repeat (2) @(posedge clk);

    step(); rd(0, 1); rd(1, 2);
    expect_rd(0, 32'h0, 1'b0, "reset_r1"); expect_rd(1, 32'h0, 1'b0, "reset_r2");

    step(); wr(0, 5, 32'hA5A5_A5A5); wr(1, 10, 32'h0000_1234); issue(11); rd(0, 5); rd(1, 10);
    expect_rd(0, 32'hA5A5_A5A5, 1'b0, "pre_rst_byp_r5"); expect_rd(1, 32'h1234, 1'b0, "pre_rst_byp_r10");

    step(); rst = 1'b1; wr(0, 5, 32'h5555_5555); rd(0, 5); rd(1, 11);
    expect_rd(1, 32'h0, 1'b1, "rst_cycle_r11_busy");

    step(); rd(0, 5); rd(1, 11);
    expect_rd(0, 32'h0, 1'b0, "post_rst_r5"); expect_rd(1, 32'h0, 1'b0, "post_rst_r11");
    step(); rd(0, 10); rd(1, 5);
    expect_rd(0, 32'h0, 1'b0, "post_rst_r10"); expect_rd(1, 32'h0, 1'b0, "post_rst_r5_p1");

    step(); wr(0, 7, 32'hDEAD_BEEF); rd(1, 7);
    expect_rd(1, 32'hDEAD_BEEF, 1'b0, "bypass_r7");
    step(); rd(1, 7);
    expect_rd(1, 32'hDEAD_BEEF, 1'b0, "stored_r7");

    step(); wr(0, 3, 32'h1111); wr(1, 3, 32'h2222); rd(0, 3);
    expect_rd(0, 32'h2222, 1'b0, "collision_byp_r3");
    step(); rd(0, 3); rd(1, 7);
    expect_rd(0, 32'h2222, 1'b0, "collision_stored_r3"); expect_rd(1, 32'hDEAD_BEEF, 1'b0, "r7_hold");

    step(); wr(0, 0, 32'hFFFF_FFFF); wr(1, 0, 32'hFFFF_FFFF); issue(0); rd(0, 0); rd(1, 0);
    expect_rd(0, 32'h0, 1'b0, "zero_write_cycle_p0"); expect_rd(1, 32'h0, 1'b0, "zero_write_cycle_p1");
    step(); rd(0, 0); rd(1, 0);
    expect_rd(0, 32'h0, 1'b0, "zero_after_p0"); expect_rd(1, 32'h0, 1'b0, "zero_after_p1");
    step(); rd(0, 0);
    expect_rd(0, 32'h0, 1'b0, "zero_later");

    step(); issue(9); rd(0, 9);
    expect_rd(0, 32'h0, 1'b0, "issue_own_cycle_r9");
    for (int k = 1; k <= 3; k++) begin
      step(); rd(0, 9); rd(1, 9);
      expect_rd(0, 32'h0, 1'b1, "r9_busy_p0"); expect_busy(1, 1'b1, "r9_busy_p1");
    end
    step(); wr(1, 9, 32'h42); rd(0, 9); rd(1, 9);
    expect_rd(0, 32'h42, 1'b0, "r9_writeback_byp"); expect_rd(1, 32'h42, 1'b0, "r9_writeback_byp_p1");
    step(); rd(0, 9);
    expect_rd(0, 32'h42, 1'b0, "r9_after_writeback");

    step(); issue(9); wr(0, 9, 32'h77); rd(0, 9);
    expect_rd(0, 32'h77, 1'b0, "issue_write_same_cycle");
    step(); rd(0, 9);
    expect_rd(0, 32'h77, 1'b1, "issue_beats_write");

    step(); issue(1);
    step(); issue(2); rd(0, 1);
    expect_busy(0, 1'b1, "r1_busy");
    step(); issue(4); rd(0, 2);
    expect_busy(0, 1'b1, "r2_busy");
    step(); flush = 1'b1; issue(6); rd(0, 4); rd(1, 2);
    expect_busy(0, 1'b1, "flush_cycle_r4"); expect_busy(1, 1'b1, "flush_cycle_r2");
    step(); rd(0, 1); rd(1, 6);
    expect_busy(0, 1'b0, "flushed_r1"); expect_busy(1, 1'b1, "issued_r6");
    step(); rd(0, 2); rd(1, 4);
    expect_busy(0, 1'b0, "flushed_r2"); expect_busy(1, 1'b0, "flushed_r4");
    step(); rd(0, 9); rd(1, 6);
    expect_rd(0, 32'h77, 1'b0, "flush_keeps_data_r9"); expect_busy(1, 1'b1, "r6_still_busy");

    step();
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
